// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_seq_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned CNT_W_DEF = 16;

    // Truncate to XLEN with an explicit cast; clears the byte offset within a word.
    localparam logic [63:0] WORD_ALIGN_MASK = ~64'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        XLATE = 3'd1,
        ICREQ = 3'd2,
        DRAIN = 3'd3,
        FAULT = 3'd4
    } type_fseq_state_e;

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Prefetch, MMU and icache handshake bundle seen by the fetch sequencer.
interface fetch_seq_ctrl_if
    import fetch_seq_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             pf_req_i;
    logic [XLEN-1:0]  pf_vaddr_i;
    logic             pf_flush_i;
    logic             pf_ack_o;
    logic [XLEN-1:0]  pf_data_o;
    logic             pf_fault_o;
    logic             mmu_req_o;
    logic [XLEN-1:0]  mmu_vaddr_o;
    logic             mmu_hit_i;
    logic [XLEN-1:0]  mmu_paddr_i;
    logic             mmu_fault_i;
    logic             ic_req_o;
    logic [XLEN-1:0]  ic_addr_o;
    logic             ic_ack_i;
    logic [XLEN-1:0]  ic_data_i;
    logic [CNT_W-1:0] stall_cnt_o;

    // Sequencer side.
    modport master (
        input  pf_req_i, pf_vaddr_i, pf_flush_i,
        input  mmu_hit_i, mmu_paddr_i, mmu_fault_i,
        input  ic_ack_i, ic_data_i,
        output pf_ack_o, pf_data_o, pf_fault_o,
        output mmu_req_o, mmu_vaddr_o,
        output ic_req_o, ic_addr_o,
        output stall_cnt_o
    );

    // Environment side: prefetch, MMU and icache.
    modport slave (
        output pf_req_i, pf_vaddr_i, pf_flush_i,
        output mmu_hit_i, mmu_paddr_i, mmu_fault_i,
        output ic_ack_i, ic_data_i,
        input  pf_ack_o, pf_data_o, pf_fault_o,
        input  mmu_req_o, mmu_vaddr_o,
        input  ic_req_o, ic_addr_o,
        input  stall_cnt_o
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: prefetch request -> MMU translation -> icache read,
// with flush suppression of stale responses and a stall-cycle counter.
module fetch_seq_ctrl
    import fetch_seq_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_seq_ctrl_if.master bus
);

    localparam logic [XLEN-1:0] ALIGN = XLEN'(WORD_ALIGN_MASK);

    type_fseq_state_e state_q, state_d;
    logic [XLEN-1:0]  vaddr_q, vaddr_d;
    logic [XLEN-1:0]  paddr_q, paddr_d;
    logic [XLEN-1:0]  data_q,  data_d;
    logic             ack_q,   ack_d;
    logic             flush;
    logic             pf_ack;
    logic             stall_inc;

    assign flush = bus.pf_flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vaddr_q <= '0;
            paddr_q <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vaddr_q <= vaddr_d;
            paddr_q <= paddr_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    // Flush is honoured at the same edge in every state except DRAIN, which must
    // finish the icache handshake before any new request is taken.
    always_comb begin
        state_d = state_q;
        vaddr_d = vaddr_q;
        paddr_d = paddr_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.pf_req_i && !flush) begin
                    vaddr_d = bus.pf_vaddr_i & ALIGN;
                    state_d = XLATE;
                end
            end
            XLATE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (bus.mmu_fault_i) begin
                    state_d = FAULT;
                end else if (bus.mmu_hit_i) begin
                    paddr_d = bus.mmu_paddr_i & ALIGN;
                    state_d = ICREQ;
                end
            end
            ICREQ: begin
                if (bus.ic_ack_i) begin
                    if (!flush) begin
                        data_d = bus.ic_data_i;
                        ack_d  = 1'b1;
                    end
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.ic_ack_i) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (flush) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Downstream requests depend on registered state only.
    assign pf_ack          = ack_q & ~flush;
    assign bus.pf_ack_o    = pf_ack;
    assign bus.pf_data_o   = data_q;
    assign bus.pf_fault_o  = (state_q == FAULT);
    assign bus.mmu_req_o   = (state_q == XLATE);
    assign bus.mmu_vaddr_o = vaddr_q;
    assign bus.ic_req_o    = (state_q == ICREQ) || (state_q == DRAIN);
    assign bus.ic_addr_o   = paddr_q;

    assign stall_inc = bus.pf_req_i & ~pf_ack & (state_q != FAULT);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_inc),
        .cnt_o (bus.stall_cnt_o)
    );

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl with hand-computed expectations (CNT_W=4).
module tb_fetch_seq_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_seq_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    fetch_seq_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pf_ack"},    32'(bus.pf_ack_o),    32'd0);
        chk({tag, ".pf_data"},   bus.pf_data_o,        32'd0);
        chk({tag, ".pf_fault"},  32'(bus.pf_fault_o),  32'd0);
        chk({tag, ".mmu_req"},   32'(bus.mmu_req_o),   32'd0);
        chk({tag, ".mmu_vaddr"}, bus.mmu_vaddr_o,      32'd0);
        chk({tag, ".ic_req"},    32'(bus.ic_req_o),    32'd0);
        chk({tag, ".ic_addr"},   bus.ic_addr_o,        32'd0);
        chk({tag, ".stall"},     32'(bus.stall_cnt_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        bus.pf_req_i    = 1'b0;
        bus.pf_vaddr_i  = '0;
        bus.pf_flush_i  = 1'b0;
        bus.mmu_hit_i   = 1'b0;
        bus.mmu_paddr_i = '0;
        bus.mmu_fault_i = 1'b0;
        bus.ic_ack_i    = 1'b0;
        bus.ic_data_i   = '0;
        #3;
        chk_all_zero("reset");
        tick();
        rst_n = 1'b1;

        // Basic zero-wait fetch
        bus.pf_req_i = 1'b1; bus.pf_vaddr_i = 32'h8000_0006;
        tick();
        bus.pf_req_i = 1'b0; bus.mmu_hit_i = 1'b1; bus.mmu_paddr_i = 32'h8000_0006;
        #1;
        chk("basic.c1.mmu_req",   32'(bus.mmu_req_o), 32'd1);
        chk("basic.c1.mmu_vaddr", bus.mmu_vaddr_o,    32'h8000_0004);
        chk("basic.c1.ic_req",    32'(bus.ic_req_o),  32'd0);
        tick();
        bus.mmu_hit_i = 1'b0; bus.ic_ack_i = 1'b1; bus.ic_data_i = 32'h1234_5678;
        #1;
        chk("basic.c2.ic_req",  32'(bus.ic_req_o),  32'd1);
        chk("basic.c2.ic_addr", bus.ic_addr_o,      32'h8000_0004);
        chk("basic.c2.mmu_req", 32'(bus.mmu_req_o), 32'd0);
        chk("basic.c2.pf_ack",  32'(bus.pf_ack_o),  32'd0);
        tick();
        bus.ic_ack_i = 1'b0;
        #1;
        chk("basic.c3.pf_ack",  32'(bus.pf_ack_o), 32'd1);
        chk("basic.c3.pf_data", bus.pf_data_o,     32'h1234_5678);
        tick();
        chk("basic.c4.pf_ack",  32'(bus.pf_ack_o), 32'd0);
        chk("basic.c4.pf_data", bus.pf_data_o,     32'h1234_5678);

        // MMU waits 2 cycles, icache waits 3 cycles: ack at cycle 8, 8 stall cycles
        pulse_reset();
        bus.pf_req_i = 1'b1; bus.pf_vaddr_i = 32'h0000_1000;
        tick();
        chk("wait.c1.mmu_req", 32'(bus.mmu_req_o), 32'd1);
        tick();
        chk("wait.c2.mmu_req", 32'(bus.mmu_req_o), 32'd1);
        tick();
        bus.mmu_hit_i = 1'b1; bus.mmu_paddr_i = 32'h0004_200B;
        tick();
        bus.mmu_hit_i = 1'b0;
        chk("wait.c4.ic_req",  32'(bus.ic_req_o), 32'd1);
        chk("wait.c4.ic_addr", bus.ic_addr_o,     32'h0004_2008);
        tick();
        chk("wait.c5.ic_addr", bus.ic_addr_o,     32'h0004_2008);
        tick();
        chk("wait.c6.ic_addr", bus.ic_addr_o,     32'h0004_2008);
        tick();
        bus.ic_ack_i = 1'b1; bus.ic_data_i = 32'hCAFE_F00D;
        #1;
        chk("wait.c7.ic_addr", bus.ic_addr_o,     32'h0004_2008);
        chk("wait.c7.pf_ack",  32'(bus.pf_ack_o), 32'd0);
        tick();
        bus.ic_ack_i = 1'b0; bus.pf_req_i = 1'b0;
        #1;
        chk("wait.c8.pf_ack",  32'(bus.pf_ack_o), 32'd1);
        chk("wait.c8.pf_data", bus.pf_data_o,     32'hCAFE_F00D);
        tick();
        chk("wait.c9.stall",   32'(bus.stall_cnt_o), 32'd8);

        // Flush in ICREQ -> DRAIN until the icache acks; pf_req ignored meanwhile
        bus.pf_req_i = 1'b1; bus.pf_vaddr_i = 32'h0000_0100;
        tick();
        bus.mmu_hit_i = 1'b1; bus.mmu_paddr_i = 32'h0000_0100;
        tick();
        bus.mmu_hit_i = 1'b0; bus.pf_flush_i = 1'b1;
        #1;
        chk("drain.c2.ic_req", 32'(bus.ic_req_o), 32'd1);
        tick();
        bus.pf_flush_i = 1'b0;
        #1;
        chk("drain.c3.ic_req",  32'(bus.ic_req_o),  32'd1);
        chk("drain.c3.ic_addr", bus.ic_addr_o,      32'h0000_0100);
        chk("drain.c3.mmu_req", 32'(bus.mmu_req_o), 32'd0);
        chk("drain.c3.pf_ack",  32'(bus.pf_ack_o),  32'd0);
        tick();
        bus.ic_ack_i = 1'b1; bus.ic_data_i = 32'hDEAD_BEEF;
        #1;
        chk("drain.c4.ic_req", 32'(bus.ic_req_o), 32'd1);
        chk("drain.c4.pf_ack", 32'(bus.pf_ack_o), 32'd0);
        tick();
        bus.ic_ack_i = 1'b0; bus.pf_vaddr_i = 32'h0000_0200;
        #1;
        chk("drain.c5.pf_ack",  32'(bus.pf_ack_o),  32'd0);
        chk("drain.c5.pf_data", bus.pf_data_o,      32'hCAFE_F00D);
        chk("drain.c5.ic_req",  32'(bus.ic_req_o),  32'd0);
        chk("drain.c5.mmu_req", 32'(bus.mmu_req_o), 32'd0);
        tick();
        bus.pf_req_i = 1'b0; bus.mmu_hit_i = 1'b1; bus.mmu_paddr_i = 32'h0000_0200;
        #1;
        chk("drain.c6.mmu_req",   32'(bus.mmu_req_o), 32'd1);
        chk("drain.c6.mmu_vaddr", bus.mmu_vaddr_o,    32'h0000_0200);
        tick();
        bus.mmu_hit_i = 1'b0; bus.ic_ack_i = 1'b1; bus.ic_data_i = 32'h1111_2222;
        tick();
        bus.ic_ack_i = 1'b0;
        #1;
        chk("drain.c8.pf_ack",  32'(bus.pf_ack_o), 32'd1);
        chk("drain.c8.pf_data", bus.pf_data_o,     32'h1111_2222);
        tick();

        // Fault has priority over hit; held until flush
        pulse_reset();
        bus.pf_req_i = 1'b1; bus.pf_vaddr_i = 32'h0000_3000;
        tick();
        bus.mmu_fault_i = 1'b1; bus.mmu_hit_i = 1'b1; bus.mmu_paddr_i = 32'h0000_3000;
        tick();
        bus.mmu_fault_i = 1'b0; bus.mmu_hit_i = 1'b0;
        #1;
        chk("fault.c2.pf_fault", 32'(bus.pf_fault_o), 32'd1);
        chk("fault.c2.ic_req",   32'(bus.ic_req_o),   32'd0);
        chk("fault.c2.mmu_req",  32'(bus.mmu_req_o),  32'd0);
        tick();
        chk("fault.c3.ic_req",   32'(bus.ic_req_o),   32'd0);
        tick();
        chk("fault.c4.pf_fault", 32'(bus.pf_fault_o), 32'd1);
        tick();
        bus.pf_req_i = 1'b0; bus.pf_flush_i = 1'b1;
        #1;
        chk("fault.c5.pf_fault", 32'(bus.pf_fault_o), 32'd1);
        chk("fault.c5.ic_req",   32'(bus.ic_req_o),   32'd0);
        tick();
        bus.pf_flush_i = 1'b0;
        #1;
        chk("fault.c6.pf_fault", 32'(bus.pf_fault_o),  32'd0);
        chk("fault.c6.mmu_req",  32'(bus.mmu_req_o),   32'd0);
        chk("fault.c6.stall",    32'(bus.stall_cnt_o), 32'd2);

        // icache ack coincident with flush: data dropped
        bus.pf_req_i = 1'b1; bus.pf_vaddr_i = 32'h0000_0400;
        tick();
        bus.pf_req_i = 1'b0; bus.mmu_hit_i = 1'b1; bus.mmu_paddr_i = 32'h0000_0400;
        tick();
        bus.mmu_hit_i = 1'b0; bus.ic_ack_i = 1'b1; bus.ic_data_i = 32'h55AA_55AA;
        bus.pf_flush_i = 1'b1;
        tick();
        bus.ic_ack_i = 1'b0; bus.pf_flush_i = 1'b0;
        #1;
        chk("ackflush.pf_ack",  32'(bus.pf_ack_o),  32'd0);
        chk("ackflush.pf_data", bus.pf_data_o,      32'd0);
        chk("ackflush.ic_req",  32'(bus.ic_req_o),  32'd0);
        chk("ackflush.mmu_req", 32'(bus.mmu_req_o), 32'd0);
        tick();

        // Flush in the ack cycle masks pf_ack
        bus.pf_req_i = 1'b1; bus.pf_vaddr_i = 32'h0000_0500;
        tick();
        bus.pf_req_i = 1'b0; bus.mmu_hit_i = 1'b1; bus.mmu_paddr_i = 32'h0000_0500;
        tick();
        bus.mmu_hit_i = 1'b0; bus.ic_ack_i = 1'b1; bus.ic_data_i = 32'h0BAD_F00D;
        tick();
        bus.ic_ack_i = 1'b0; bus.pf_flush_i = 1'b1;
        #1;
        chk("flushack.c3.pf_ack",  32'(bus.pf_ack_o), 32'd0);
        chk("flushack.c3.pf_data", bus.pf_data_o,     32'h0BAD_F00D);
        tick();
        bus.pf_flush_i = 1'b0;
        #1;
        chk("flushack.c4.pf_ack",  32'(bus.pf_ack_o), 32'd0);

        // Asynchronous reset mid-XLATE
        bus.pf_req_i = 1'b1; bus.pf_vaddr_i = 32'h0000_0600;
        tick();
        chk("rstmid.pre.mmu_req", 32'(bus.mmu_req_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstmid");
        rst_n = 1'b1;

        // Stall counter saturates at 15 with CNT_W=4
        bus.pf_vaddr_i = 32'h0000_0700;
        repeat (14) tick();
        chk("sat.14", 32'(bus.stall_cnt_o), 32'd14);
        repeat (6) tick();
        chk("sat.20", 32'(bus.stall_cnt_o), 32'd15);
        repeat (2) tick();
        chk("sat.22", 32'(bus.stall_cnt_o), 32'd15);
        bus.pf_req_i = 1'b0; bus.pf_flush_i = 1'b1;
        tick();
        bus.pf_flush_i = 1'b0;
        #1;
        chk("sat.flush.stall",   32'(bus.stall_cnt_o), 32'd15);
        chk("sat.flush.mmu_req", 32'(bus.mmu_req_o),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
